// File: rtl/approx_mul_pkg.sv
// Shared constants, types and helpers for the
// pipelined truncated approximate multiplier.
package approx_mul_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_PIPE_STAGES = 3;
  localparam int DEF_CUT_W = $clog2(2 * DEF_WIDTH);

  function automatic int cut_w(input int width);
    return $clog2(2 * width);
  endfunction

  typedef struct packed {
    logic [2*DEF_WIDTH-1:0] psum;
    logic [DEF_CUT_W-1:0]   cut;
    logic                   rnd;
  } stage_t;

endpackage

// File: rtl/approx_mul_if.sv
// Operand/result valid-ready bundle for approx_mul_pipe.
// master drives operands and out_ready, slave is the multiplier.
interface approx_mul_if
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CUT_W = cut_w(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [CUT_W-1:0]   in_cut;
  logic               in_round;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic [CUT_W-1:0]   out_cut;

  modport master (
    output in_valid, in_a, in_b,
    output in_cut, in_round, out_ready,
    input  in_ready, out_valid,
    input  out_p, out_cut
  );

  modport slave (
    input  in_valid, in_a, in_b,
    input  in_cut, in_round, out_ready,
    output in_ready, out_valid,
    output out_p, out_cut
  );

endinterface

// File: rtl/approx_mul_pipe_reduce.sv
// Sums the partial-product rows selected by b whose
// bit weight is at or above cut, plus optional rounding.
module approx_pp_reduce
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CUT_W = cut_w(WIDTH)
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [CUT_W-1:0]   cut,
  input  logic               rnd,
  output logic [2*WIDTH-1:0] p
);
  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] keep;
  logic [PW-1:0] acc;

  // Bit position i+j of a row equals its pp weight,
  // so one mask on the shifted row drops i+j < cut.
  always_comb begin
    keep = {PW{1'b1}} << cut;
    acc = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (b[j]) begin
        acc = acc
          + (({{WIDTH{1'b0}}, a} << j) & keep);
      end
    end
    if (rnd && (cut != '0)) begin
      acc = acc + (PW'(1) << (cut - CUT_W'(1)));
    end
    p = acc;
  end

endmodule

// File: rtl/approx_mul_pipe.sv
// Pipelined truncated multiplier: each stage adds its
// share of multiplier rows, with bubble-collapsing flow.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PIPE_STAGES = DEF_PIPE_STAGES,
  parameter int CUT_W = cut_w(WIDTH)
) (
  input logic         clk,
  input logic         rst_n,
  approx_mul_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int S = PIPE_STAGES;

  typedef struct packed {
    logic [PW-1:0]    psum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [CUT_W-1:0] cut;
    logic             rnd;
  } pl_t;

  function automatic logic [WIDTH-1:0] grp_mask(
    input int k
  );
    logic [WIDTH-1:0] m;
    m = '0;
    for (int j = 0; j < WIDTH; j++) begin
      m[j] = ((j * S) / WIDTH) == k;
    end
    return m;
  endfunction

  logic [S-1:0]  vld_q, vld_d;
  logic [S-1:0]  take;
  logic [S-1:0]  src_v;
  logic [S-1:0]  carry;
  pl_t           pl_q [S];
  pl_t           pl_d [S];
  pl_t           src [S];
  logic [PW-1:0] part [S];
  logic [PW:0]   sum_x [S];
  logic [CUT_W-1:0] cut_in;

  if ((1 << CUT_W) > PW) begin : g_clamp
    localparam logic [CUT_W-1:0] CMAX = CUT_W'(PW - 1);
    assign cut_in = (bus.in_cut > CMAX) ? CMAX
                                        : bus.in_cut;
  end else begin : g_pass
    assign cut_in = bus.in_cut;
  end

  for (genvar k = 0; k < S; k++) begin : g_st
    localparam logic [WIDTH-1:0] GM = grp_mask(k);
    localparam bit FIRST = (k == 0);

    if (k == 0) begin : g_src0
      assign src[k] = '{psum: '0,
                        a: bus.in_a,
                        b: bus.in_b,
                        cut: cut_in,
                        rnd: bus.in_round};
      assign src_v[k] = bus.in_valid;
    end else begin : g_srcn
      assign src[k] = pl_q[k-1];
      assign src_v[k] = vld_q[k-1];
    end

    approx_pp_reduce #(
      .WIDTH(WIDTH),
      .CUT_W(CUT_W)
    ) u_red (
      .a  (src[k].a),
      .b  (src[k].b & GM),
      .cut(src[k].cut),
      .rnd(src[k].rnd & FIRST),
      .p  (part[k])
    );

    assign sum_x[k] = {1'b0, src[k].psum}
                    + {1'b0, part[k]};
    assign carry[k] = sum_x[k][PW] & src_v[k];
  end

  // A stage can load when empty or when it drains
  // into a stage that is itself able to load.
  always_comb begin
    logic t;
    t = bus.out_ready;
    take = '0;
    for (int k = S - 1; k >= 0; k--) begin
      t = ~vld_q[k] | t;
      take[k] = t;
    end
  end

  always_comb begin
    for (int k = 0; k < S; k++) begin
      vld_d[k] = vld_q[k];
      pl_d[k] = pl_q[k];
      if (take[k]) begin
        vld_d[k] = src_v[k];
        if (src_v[k]) begin
          pl_d[k] = src[k];
          pl_d[k].psum = sum_x[k][PW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < S; k++) pl_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < S; k++) pl_q[k] <= pl_d[k];
    end
  end

  assign bus.in_ready = take[0];
  assign bus.out_valid = vld_q[S-1];
  assign bus.out_p = pl_q[S-1].psum;
  assign bus.out_cut = pl_q[S-1].cut;

  no_carry_out: assert property (
    @(posedge clk) disable iff (!rst_n) ~|carry
  );

endmodule
